// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined ALU: opcode set, status flags and MUL FSM states.
// Opcodes 12-15 are reserved and execute as a single-cycle error result.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        IOR = 4'd3,
        XOR = 4'd4,
        NOT = 4'd5,
        LSL = 4'd6,
        LSR = 4'd7,
        SLT = 4'd8,
        SEQ = 4'd9,
        ASR = 4'd10,
        MUL = 4'd11
    } op_mne_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic ovf;
        logic err;
    } alu_flags_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } alu_state_e;

    localparam int OP_W = 4;

endpackage

// File: rtl/alu_comb.sv
// Combinational datapath for every single-cycle opcode plus its status flags.
// MUL is handled by the iterative engine in alu_pipe; here it yields zero.
module alu_comb
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output alu_flags_t       flags_o
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  sh_amt;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] res;
    alu_flags_t       flg;

    assign sh_amt = b_i[SH_W-1:0];
    assign add_w  = {1'b0, a_i} + {1'b0, b_i};
    // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
    assign sub_w  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        res = '0;
        flg = '0;
        case (op_mne_e'(op_i))
            ADD: begin
                res       = add_w[WIDTH-1:0];
                flg.carry = add_w[WIDTH];
                flg.ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                            (add_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            SUB: begin
                res       = sub_w[WIDTH-1:0];
                flg.carry = sub_w[WIDTH];
                flg.ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                            (sub_w[WIDTH-1] != a_i[WIDTH-1]);
            end
            AND: res = a_i & b_i;
            IOR: res = a_i | b_i;
            XOR: res = a_i ^ b_i;
            NOT: res = ~a_i;
            LSL: res = a_i << sh_amt;
            LSR: res = a_i >> sh_amt;
            ASR: res = $signed(a_i) >>> sh_amt;
            SLT: res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            SEQ: res = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
            MUL: res = '0;
            default: flg.err = 1'b1;
        endcase
        flg.zero = (res == '0);
    end

    assign result_o = res;
    assign flags_o  = flg;

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops land in the output register one edge after issue,
// MUL runs a WIDTH-cycle shift-add loop; issue stalls while busy or while a result is stuck.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_err
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_state_e       state_q;
    logic [WIDTH-1:0] ma_q;
    logic [WIDTH-1:0] mb_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] mtag_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic [TAG_W-1:0] out_tag_q;
    alu_flags_t       out_flags_q;

    logic [WIDTH-1:0] comb_result;
    alu_flags_t       comb_flags;
    logic             accept;
    logic             is_mul;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .op_i     (in_op),
        .a_i      (in_a),
        .b_i      (in_b),
        .result_o (comb_result),
        .flags_o  (comb_flags)
    );

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (op_mne_e'(in_op) == MUL);
    assign acc_d    = acc_q + (mb_q[0] ? ma_q : '0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            ma_q         <= '0;
            mb_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            mtag_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_tag_q    <= '0;
            out_flags_q  <= '0;
        end else begin
            // Drain first; a load below on the same edge takes precedence.
            if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state_q <= BUSY;
                            ma_q    <= in_a;
                            mb_q    <= in_b;
                            acc_q   <= '0;
                            cnt_q   <= CNT_W'(WIDTH);
                            mtag_q  <= in_tag;
                        end else begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= comb_result;
                            out_tag_q    <= in_tag;
                            out_flags_q  <= comb_flags;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    ma_q  <= ma_q << 1;
                    mb_q  <= mb_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                    // Output register is guaranteed empty here: MUL issue required it drained.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q      <= IDLE;
                        out_valid_q  <= 1'b1;
                        out_result_q <= acc_d;
                        out_tag_q    <= mtag_q;
                        out_flags_q  <= '{zero: (acc_d == '0), carry: 1'b0,
                                          ovf: 1'b0, err: 1'b0};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
    assign out_zero   = out_flags_q.zero;
    assign out_carry  = out_flags_q.carry;
    assign out_ovf    = out_flags_q.ovf;
    assign out_err    = out_flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: directed vectors, MUL latency, back-pressure and reset abort.
module tb_alu_pipe;

    logic       Clk;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [1:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [1:0] out_tag;
    logic       out_zero;
    logic       out_carry;
    logic       out_ovf;
    logic       out_err;

    alu_pipe #(
        .WIDTH (8),
        .TAG_W (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_zero   (out_zero),
        .out_carry  (out_carry),
        .out_ovf    (out_ovf),
        .out_err    (out_err)
    );

    typedef struct {
        logic [7:0] res;
        logic [1:0] tag;
        logic [3:0] flg;   // {zero, carry, ovf, err}
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic exp_t mk(input logic [7:0] res, input logic [1:0] tag,
                                input logic z, input logic c, input logic o, input logic e);
        exp_t x;
        x.res = res;
        x.tag = tag;
        x.flg = {z, c, o, e};
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares whenever a result is actually transferred.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (!Reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_result: got 0x%0h tag %0d, expected none", out_result, out_tag);
                end else begin
                    e = sb.pop_front();
                    chk("result", {24'd0, out_result}, {24'd0, e.res});
                    chk("tag", {30'd0, out_tag}, {30'd0, e.tag});
                    chk("flags", {28'd0, out_zero, out_carry, out_ovf, out_err}, {28'd0, e.flg});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] tag, input exp_t e);
        int waited;
        bit got;
        in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 50) begin
            @(negedge Clk);
            if (in_ready) got = 1'b1;
            waited++;
        end
        if (!got) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else begin
            sb.push_back(e);
            @(posedge Clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb.size() != 0 || out_valid) && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        chk("drain", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        int  busy_cnt;
        bit  ov_seen;
        Reset = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", {24'd0, out_result}, 32'd0);
        chk("rst_flags", {28'd0, out_zero, out_carry, out_ovf, out_err}, 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;

        // Directed single-cycle vectors, issued back to back.
        issue(4'd0,  8'h7F, 8'h01, 2'd0, mk(8'h80, 2'd0, 0, 0, 1, 0));
        issue(4'd1,  8'h05, 8'h05, 2'd1, mk(8'h00, 2'd1, 1, 1, 0, 0));
        issue(4'd10, 8'h90, 8'h0A, 2'd2, mk(8'hE4, 2'd2, 0, 0, 0, 0));
        issue(4'd7,  8'h90, 8'h02, 2'd3, mk(8'h24, 2'd3, 0, 0, 0, 0));
        issue(4'd8,  8'hFF, 8'h01, 2'd0, mk(8'h01, 2'd0, 0, 0, 0, 0));
        issue(4'd8,  8'h01, 8'hFF, 2'd1, mk(8'h00, 2'd1, 1, 0, 0, 0));
        issue(4'd9,  8'h3C, 8'h3C, 2'd2, mk(8'h01, 2'd2, 0, 0, 0, 0));
        issue(4'd9,  8'h3C, 8'h3D, 2'd3, mk(8'h00, 2'd3, 1, 0, 0, 0));
        issue(4'd0,  8'hFF, 8'h01, 2'd0, mk(8'h00, 2'd0, 1, 1, 0, 0));
        issue(4'd1,  8'h00, 8'h01, 2'd1, mk(8'hFF, 2'd1, 0, 0, 0, 0));
        issue(4'd1,  8'h80, 8'h01, 2'd2, mk(8'h7F, 2'd2, 0, 1, 1, 0));
        issue(4'd2,  8'hF0, 8'h3C, 2'd3, mk(8'h30, 2'd3, 0, 0, 0, 0));
        issue(4'd3,  8'hF0, 8'h0F, 2'd0, mk(8'hFF, 2'd0, 0, 0, 0, 0));
        issue(4'd4,  8'hFF, 8'h0F, 2'd1, mk(8'hF0, 2'd1, 0, 0, 0, 0));
        issue(4'd5,  8'h0F, 8'hAA, 2'd2, mk(8'hF0, 2'd2, 0, 0, 0, 0));
        issue(4'd6,  8'h81, 8'h09, 2'd3, mk(8'h02, 2'd3, 0, 0, 0, 0));
        issue(4'd14, 8'h12, 8'h34, 2'd0, mk(8'h00, 2'd0, 1, 0, 0, 1));
        issue(4'd12, 8'h05, 8'h05, 2'd1, mk(8'h00, 2'd1, 1, 0, 0, 1));
        issue(4'd11, 8'hFF, 8'hFF, 2'd2, mk(8'h01, 2'd2, 0, 0, 0, 0));
        issue(4'd11, 8'h10, 8'h10, 2'd3, mk(8'h00, 2'd3, 1, 0, 0, 0));
        drain();

        // MUL latency, with a second op held on the input throughout BUSY.
        in_op = 4'd11; in_a = 8'd13; in_b = 8'd11; in_tag = 2'd2; in_valid = 1'b1;
        @(negedge Clk);
        chk("mul_accept_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(mk(8'h8F, 2'd2, 0, 0, 0, 0));
        @(posedge Clk); #1;
        in_op = 4'd0; in_a = 8'h11; in_b = 8'h22; in_tag = 2'd1;
        busy_cnt = 0;
        ov_seen = 1'b0;
        while (busy_cnt < 20) begin
            @(negedge Clk);
            if (in_ready) break;
            if (out_valid) ov_seen = 1'b1;
            busy_cnt++;
        end
        chk("mul_busy_cycles", busy_cnt, 32'd8);
        chk("mul_no_early_valid", {31'd0, ov_seen}, 32'd0);
        chk("mul_valid_after_k8", {31'd0, out_valid}, 32'd1);
        sb.push_back(mk(8'h33, 2'd1, 0, 0, 0, 0));
        @(posedge Clk); #1;
        in_valid = 1'b0;
        drain();

        // Back-pressure: result must hold while the consumer stalls.
        out_ready = 1'b0;
        issue(4'd0, 8'h10, 8'h20, 2'd1, mk(8'h30, 2'd1, 0, 0, 0, 0));
        in_op = 4'd1; in_a = 8'h09; in_b = 8'h03; in_tag = 2'd3; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
            chk("bp_result_held", {24'd0, out_result}, 32'h30);
            chk("bp_tag_held", {30'd0, out_tag}, 32'd1);
        end
        @(posedge Clk); #1;
        out_ready = 1'b1;
        @(negedge Clk);
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(mk(8'h06, 2'd3, 0, 1, 0, 0));
        @(posedge Clk); #1;
        in_valid = 1'b0;
        @(negedge Clk);
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        @(posedge Clk); #1;
        drain();

        // Reset in the middle of a MUL: no result may emerge.
        in_op = 4'd11; in_a = 8'd7; in_b = 8'd9; in_tag = 2'd1; in_valid = 1'b1;
        @(posedge Clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        chk("rst_busy_ready", {31'd0, in_ready}, 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_result", {24'd0, out_result}, 32'd0);
        ov_seen = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            if (out_valid) ov_seen = 1'b1;
        end
        chk("rst_no_stale", {31'd0, ov_seen}, 32'd0);
        @(posedge Clk); #1;

        issue(4'd0, 8'h01, 8'h02, 2'd3, mk(8'h03, 2'd3, 0, 0, 0, 0));
        drain();
        chk("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
